// File: rtl/ballot_counter_n.sv
// ballot_counter_n: N-candidate tally engine with debounced buttons, saturating counts and leader/tie tracking; VOTE_ARM_EN makes every ballot need an officer arm.
// Latency: count/vote_ack DEBOUNCE+1 edges after the first high button sample; leader/tie one edge after a count changes.
// Backpressure: none; presses outside ARMED/RESULT and arm outside IDLE are dropped, never queued.
module ballot_counter_n #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int DEBOUNCE = 10,
    parameter int ACK_CYC  = 10,
    parameter int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] button,
    input  logic                arm,
    output logic [CNT_W-1:0]    led,
    output logic                ready,
    output logic                vote_ack,
    output logic                reject,
    output logic [IDX_W-1:0]    leader,
    output logic                tie,
    output logic                sat
);

    localparam int DB_W  = $clog2(DEBOUNCE + 2);
    localparam int ACK_W = $clog2(ACK_CYC + 1);

    localparam logic [DB_W-1:0]     DB_HIT   = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0]     DB_MAX   = DB_W'(DEBOUNCE + 1);
    localparam logic [ACK_W-1:0]    ACK_LAST = ACK_W'(ACK_CYC - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]    CNT_NEAR = CNT_MAX - CNT_W'(1);
    localparam logic [NUM_CAND-1:0] PRESS_ONE = NUM_CAND'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ACK,
        S_RESULT
    } state_t;

`ifdef VOTE_ARM_EN
    localparam state_t S_REST = S_IDLE;
`else
    localparam state_t S_REST = S_ARMED;
`endif

    state_t              state;
    logic [DB_W-1:0]     db_cnt [NUM_CAND];
    logic [NUM_CAND-1:0] press;
    logic [CNT_W-1:0]    counts [NUM_CAND];
    logic [ACK_W-1:0]    ack_cnt;
    logic [IDX_W-1:0]    sel;
    logic [IDX_W-1:0]    press_idx;
    logic                press_multi;
    logic                press_one;
    logic [CNT_W-1:0]    max_val;
    logic [IDX_W-1:0]    leader_nxt;
    logic                tie_nxt;
    logic                max_seen;

    // press is registered one edge after the counter hits DEBOUNCE, so the FSM acts DEBOUNCE+1 edges after the first high sample
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                db_cnt[i] <= '0;
            end
            press <= '0;
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (!button[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != DB_MAX) begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
                press[i] <= (db_cnt[i] == DB_HIT);
            end
        end
    end

    always_comb begin
        press_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (press[i]) begin
                press_idx = IDX_W'(i);
            end
        end
    end

    assign press_multi = |(press & (press - PRESS_ONE));
    assign press_one   = (|press) && !press_multi;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_REST;
            ack_cnt  <= '0;
            sel      <= '0;
            vote_ack <= 1'b0;
            reject   <= 1'b0;
            sat      <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                counts[i] <= '0;
            end
        end else begin
            vote_ack <= 1'b0;
            reject   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mode) begin
                        state <= S_RESULT;
                        sel   <= '0;
                    end else if (arm) begin
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (mode) begin
                        state <= S_RESULT;
                        sel   <= '0;
                    end else if (press_multi) begin
                        reject <= 1'b1;
                    end else if (press_one) begin
                        vote_ack <= 1'b1;
                        ack_cnt  <= '0;
                        state    <= S_ACK;
                        if (counts[press_idx] != CNT_MAX) begin
                            counts[press_idx] <= counts[press_idx] + CNT_W'(1);
                        end
                        // sticky flag raised once any count lands on (or is already at) all-ones
                        if (counts[press_idx] == CNT_MAX || counts[press_idx] == CNT_NEAR) begin
                            sat <= 1'b1;
                        end
                    end
                end
                S_ACK: begin
                    if (ack_cnt == ACK_LAST) begin
                        state <= S_REST;
                    end else begin
                        ack_cnt <= ack_cnt + ACK_W'(1);
                    end
                end
                S_RESULT: begin
                    if (!mode) begin
                        state <= S_REST;
                    end else if (press_one) begin
                        sel <= press_idx;
                    end
                end
                default: state <= S_REST;
            endcase
        end
    end

    always_comb begin
        max_val    = counts[0];
        leader_nxt = '0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (counts[i] > max_val) begin
                max_val    = counts[i];
                leader_nxt = IDX_W'(i);
            end
        end
        tie_nxt  = 1'b0;
        max_seen = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (counts[i] == max_val) begin
                if (max_seen) begin
                    tie_nxt = 1'b1;
                end
                max_seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            leader <= '0;
            tie    <= 1'b1;
        end else begin
            leader <= leader_nxt;
            tie    <= tie_nxt;
        end
    end

    always_comb begin
        led = '0;
        case (state)
            S_ACK:    led = CNT_MAX;
            S_RESULT: led = counts[sel];
            default:  led = '0;
        endcase
    end

    assign ready = (state == S_ARMED);

endmodule

// File: tb/tb_ballot_counter_n.sv
// Bench for ballot_counter_n: randomized ballots against an abstract tally model, plus a narrow-count instance for saturation.
module tb_ballot_counter_n;
    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 10;
    localparam int A = 10;
`ifdef VOTE_ARM_EN
    localparam bit ARM_EN = 1'b1;
`else
    localparam bit ARM_EN = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset, mode, arm;
    logic [N-1:0] button;
    logic [W-1:0] led;
    logic         ready, vote_ack, reject, tie, sat;
    logic [1:0]   leader;

    logic         reset_b, mode_b, arm_b;
    logic [1:0]   button_b;
    logic [1:0]   led_b;
    logic         ready_b, vote_ack_b, reject_b, tie_b, sat_b;
    logic [0:0]   leader_b;

    ballot_counter_n #(.NUM_CAND(N), .CNT_W(W), .DEBOUNCE(D), .ACK_CYC(A)) dut (
        .clock(clock), .reset(reset), .mode(mode), .button(button), .arm(arm),
        .led(led), .ready(ready), .vote_ack(vote_ack), .reject(reject),
        .leader(leader), .tie(tie), .sat(sat)
    );

    ballot_counter_n #(.NUM_CAND(2), .CNT_W(2), .DEBOUNCE(2), .ACK_CYC(2)) dut_b (
        .clock(clock), .reset(reset_b), .mode(mode_b), .button(button_b), .arm(arm_b),
        .led(led_b), .ready(ready_b), .vote_ack(vote_ack_b), .reject(reject_b),
        .leader(leader_b), .tie(tie_b), .sat(sat_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    int ack_b_n = 0;
    int exp_cnt [N];
    bit model_armed;

    always @(negedge clock) if (vote_ack_b) ack_b_n++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {tie, leader} from the tally table: lowest index of the maximum, tie when the maximum is shared
    function automatic logic [2:0] exp_lead();
        int best = -1;
        int ld   = 0;
        int nmax = 0;
        for (int i = 0; i < N; i++) if (exp_cnt[i] > best) begin best = exp_cnt[i]; ld = i; end
        for (int i = 0; i < N; i++) if (exp_cnt[i] == best) nmax++;
        return {(nmax > 1), ld[1:0]};
    endfunction

    function automatic logic exp_sat();
        for (int i = 0; i < N; i++) if (exp_cnt[i] == (1 << W) - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        model_armed = !ARM_EN;
    endtask

    task automatic vote(input logic [N-1:0] btns, input bit do_arm, input int hold);
        int nb;
        bit acc, rej;
        logic [2:0] lt;
        nb = $countones(btns);
        @(negedge clock);
        if (do_arm) begin
            arm = 1'b1;
            model_armed = 1'b1;
            @(negedge clock);
            arm = 1'b0;
        end
        check("ready_pre", ready, model_armed);
        acc = model_armed && nb == 1;
        rej = model_armed && nb > 1;
        button = btns;
        repeat (D + 1) @(negedge clock);
        check("ack_early", vote_ack, 0);
        @(negedge clock);
        check("vote_ack", vote_ack, acc);
        check("reject", reject, rej);
        check("led_ack", led, {W{acc}});
        if (acc) begin
            for (int i = 0; i < N; i++) if (btns[i] && exp_cnt[i] < (1 << W) - 1) exp_cnt[i]++;
            model_armed = !ARM_EN;
        end
        for (int c = 1; c < A; c++) begin
            @(negedge clock);
            if (c == hold) button = '0;
        end
        button = '0;
        check("led_last", led, {W{acc}});
        @(negedge clock);
        check("led_after", led, 0);
        check("ready_post", ready, model_armed);
        lt = exp_lead();
        check("leader", leader, lt[1:0]);
        check("tie", tie, lt[2]);
    endtask

    task automatic read_all();
        @(negedge clock);
        mode = 1'b1;
        @(negedge clock);
        check("rd_sel0", led, exp_cnt[0]);
        for (int j = 1; j < N; j++) begin
            button = '0;
            button[j] = 1'b1;
            repeat (D + 2) @(negedge clock);
            check("rd_cnt", led, exp_cnt[j]);
            button = '0;
            @(negedge clock);
        end
        button = '0;
        button[0] = 1'b1;
        button[1] = 1'b1;
        repeat (D + 2) @(negedge clock);
        check("rd_multi_led", led, exp_cnt[N-1]);
        check("rd_multi_rej", reject, 0);
        button = '0;
        mode = 1'b0;
        @(negedge clock);
        model_armed = !ARM_EN;
        check("rd_exit_ready", ready, model_armed);
    endtask

    initial begin
        logic [N-1:0] b;
        int a, c;
        bit seen;
        reset = 1'b1; mode = 1'b0; arm = 1'b0; button = '0;
        reset_b = 1'b1; mode_b = 1'b0; arm_b = 1'b0; button_b = '0;
        clear_model();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_led", led, 0);
        check("rst_ack", vote_ack, 0);
        check("rst_rej", reject, 0);
        check("rst_sat", sat, 0);
        check("rst_leader", leader, 0);
        check("rst_tie", tie, 1);
        check("rst_ready", ready, model_armed);

        vote(4'b0100, 1'b1, 5);
        vote(4'b0010, 1'b0, 3);
        vote(4'b1001, 1'b1, 2);
        vote(4'b1000, 1'b0, 2);
        vote(4'b0001, 1'b1, 1);
        vote(4'b0001, 1'b1, 4);
        vote(4'b1000, 1'b1, 3);
        read_all();

        for (int it = 0; it < 30; it++) begin
            a = $urandom_range(0, N - 1);
            b = '0;
            b[a] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                c = (a + $urandom_range(1, N - 1)) % N;
                b[c] = 1'b1;
            end
            vote(b, $urandom_range(0, 4) != 0, $urandom_range(0, 4));
        end
        read_all();
        check("sat_model", sat, exp_sat());

        // reset while the acknowledge window is showing
        @(negedge clock);
        arm = 1'b1;
        @(negedge clock);
        arm = 1'b0;
        button = 4'b0100;
        repeat (D + 2) @(negedge clock);
        check("led_pre_rst", led, {W{1'b1}});
        button = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        clear_model();
        check("ackrst_led", led, 0);
        check("ackrst_leader", leader, 0);
        check("ackrst_tie", tie, 1);
        check("ackrst_ready", ready, model_armed);
        reset = 1'b0;
        read_all();

        // reset part way through debouncing
        @(negedge clock);
        arm = 1'b1;
        @(negedge clock);
        arm = 1'b0;
        button = 4'b0010;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        button = '0;
        @(negedge clock);
        reset = 1'b0;
        clear_model();
        seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (vote_ack) seen = 1'b1;
        end
        check("dbrst_noack", seen, 0);
        check("dbrst_ready", ready, model_armed);

        // narrow counter instance: saturation at 3
        reset_b = 1'b0;
        @(negedge clock);
        for (int v = 0; v < 5; v++) begin
            @(negedge clock);
            arm_b = 1'b1;
            @(negedge clock);
            arm_b = 1'b0;
            button_b = 2'b10;
            repeat (4) @(negedge clock);
            button_b = '0;
            repeat (4) @(negedge clock);
            if (v == 1) check("sat_b_early", sat_b, 0);
        end
        check("b_ack_count", ack_b_n, 5);
        check("b_sat", sat_b, 1);
        check("b_leader", leader_b, 1);
        check("b_tie", tie_b, 0);
        mode_b = 1'b1;
        repeat (2) @(negedge clock);
        check("b_rd0", led_b, 0);
        button_b = 2'b10;
        repeat (4) @(negedge clock);
        check("b_rd1", led_b, 3);
        button_b = '0;
        mode_b = 1'b0;
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
